// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI master: FSM states and frame constants.
// Imported by spi_mstr16; no logic lives here.
// SCLK_PRELOAD parks the divider just below its SCLK fall so SCLK idles high.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PORCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Divider value held while idle (SCLK = MSB = 1, 9 clk short of the first fall)
  localparam logic [4:0] SCLK_PRELOAD = 5'b10111;

  // Bits per transaction
  localparam int SPI_LEN = 16;

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master (mode 3): one wrt pulse clocks cmd out on MOSI and captures MISO.
// Latency: done rises 521 clk after the wrt edge with the default divider width.
// wrt is ignored while a transaction is in flight; done holds until the next accepted wrt.
module spi_mstr16
  import spi_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  // Preload sits 9 counts before the all-ones wrap: MSB high, next bit low, rest ones.
  // For the default width this is exactly SCLK_PRELOAD.
  localparam logic [SCLK_DIV_W-1:0] DIV_PRE  = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_SMPL = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_SHFT = {SCLK_DIV_W{1'b1}};
  localparam logic [4:0]            LAST_BIT = 5'(SPI_LEN - 1);

  state_t                  state;
  logic [SCLK_DIV_W-1:0]   div;
  logic [4:0]              bit_cnt;
  logic [15:0]             shft_reg;
  logic                    miso_smpl;
  logic                    smpl;
  logic                    shft;

  // Divider decode: sample one clk ahead of the SCLK rise, shift at the wrap (SCLK fall)
  always_comb begin
    smpl = (div == DIV_SMPL);
    shft = (div == DIV_SHFT);
  end

  assign SCLK    = div[SCLK_DIV_W-1];
  assign MOSI    = shft_reg[15];
  assign rd_data = shft_reg;

  // Transaction FSM with inline divider, bit counter, shift register and MISO sampler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= DIV_PRE;
      bit_cnt   <= 5'd0;
      shft_reg  <= 16'h0000;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      if (smpl) begin
        miso_smpl <= MISO;
      end

      case (state)
        IDLE: begin
          div <= DIV_PRE;
          if (wrt) begin
            shft_reg <= cmd;
            done     <= 1'b0;
            bit_cnt  <= 5'd0;
            SS_n     <= 1'b0;
            state    <= PORCH;
          end
        end

        PORCH: begin
          div <= div + 1'b1;
          // First wrap is the front-porch SCLK fall: MOSI already holds bit 15, so no shift
          if (shft) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (shft) begin
            shft_reg <= {shft_reg[14:0], miso_smpl};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              // Reload instead of wrapping so there is no 17th SCLK fall
              div   <= DIV_PRE;
              SS_n  <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              div <= div + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        default: begin
          div   <= DIV_PRE;
          SS_n  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mstr16.sv
// Self-checking bench for spi_mstr16: table vectors, random transactions, corner sequences.
// MISO comes from loopback, constants, a fixed pattern or a small inertial-sensor model.
// Expected values derive from SPI framing rules, never from the DUT.
module tb_spi_mstr16;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_chk;
  int n_fail;

  // MISO source: 0 loopback, 1 tie high, 2 tie low, 3 sensor model, 4 pattern word
  int          mode;
  logic [15:0] pat;
  int          rise_idx;

  // Sensor model state
  logic [7:0]  sreg [128];
  logic [15:0] s_rx;
  logic [7:0]  s_low;
  int          snb;

  // Per-transaction observations
  int          rises;
  int          falls;
  logic [15:0] mosi_q;

  spi_mstr16 #(.SCLK_DIV_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    MISO = 1'b0;
    case (mode)
      0: MISO = MOSI;
      1: MISO = 1'b1;
      2: MISO = 1'b0;
      3: if (snb >= 8 && snb < 16) MISO = s_low[3'(15 - snb)];
      4: if (rise_idx < 16) MISO = pat[4'(15 - rise_idx)];
      default: MISO = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One transaction. repulse_at>0 pulses wrt (cmd=FFFF) so it is sampled on that edge;
  // abort_at>0 pulses rst_n low just after that edge. lat = edge index where done is seen.
  task automatic run_txn(input logic [15:0] c, input int repulse_at, input int abort_at,
                         output int lat, output logic [15:0] rd);
    int   n;
    logic prev;
    rises = 0; falls = 0; mosi_q = 16'h0; rise_idx = 0;
    snb = 0; s_rx = 16'h0; s_low = 8'h0;
    prev = SCLK;
    lat = -1;
    @(negedge clk);
    cmd = c;
    wrt = 1'b1;
    @(posedge clk);
    #1;
    wrt = 1'b0;
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_ss_low", {31'd0, SS_n}, 32'd0);
    n = 0;
    while (n < 700) begin
      wrt = (repulse_at > 0 && n + 1 == repulse_at);
      if (wrt) cmd = 16'hFFFF;
      @(posedge clk);
      #1;
      wrt = 1'b0;
      n++;
      if (SCLK !== prev && SS_n === 1'b0) begin
        if (SCLK) begin
          rises++;
          mosi_q = {mosi_q[14:0], MOSI};
          rise_idx++;
          snb++;
          s_rx = {s_rx[14:0], MOSI};
          if (snb == 8) s_low = s_rx[7] ? sreg[s_rx[6:0]] : 8'hA5;
        end else begin
          falls++;
        end
      end
      prev = SCLK;
      if (abort_at > 0 && n == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
        chk("rst_sclk", {31'd0, SCLK}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mosi", {31'd0, MOSI}, 32'd0);
        #1 rst_n = 1'b1;
        break;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    if (done && snb == 16 && !s_rx[15]) sreg[s_rx[14:8]] = s_rx[7:0];
    rd = rd_data;
  endtask

  typedef struct {
    logic [15:0] cmd;
    int          mode;
    logic [15:0] pat;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          dcount;
    logic [15:0] rd;
    logic [15:0] c;

    n_chk = 0; n_fail = 0;
    mode = 0; pat = 16'h0; rise_idx = 0; snb = 0; s_rx = 16'h0; s_low = 8'h0;
    rises = 0; falls = 0; mosi_q = 16'h0;
    for (int i = 0; i < 128; i++) sreg[i] = 8'h00;
    wrt = 1'b0; cmd = 16'h0;

    tbl[0] = '{cmd: 16'h0D02, mode: 0, pat: 16'h0000, exp_rd: 16'h0D02};
    tbl[1] = '{cmd: 16'h8F00, mode: 1, pat: 16'h0000, exp_rd: 16'hFFFF};
    tbl[2] = '{cmd: 16'h8F00, mode: 2, pat: 16'h0000, exp_rd: 16'h0000};
    tbl[3] = '{cmd: 16'h0D02, mode: 3, pat: 16'h0000, exp_rd: 16'h00A5};
    tbl[4] = '{cmd: 16'h8D00, mode: 3, pat: 16'h0000, exp_rd: 16'h0002};

    // Reset state
    rst_n = 1'b0;
    #23;
    chk("reset_ss_n", {31'd0, SS_n}, 32'd1);
    chk("reset_sclk", {31'd0, SCLK}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_rd", {16'd0, rd_data}, 32'h0);
    chk("reset_mosi", {31'd0, MOSI}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_sclk", {31'd0, SCLK}, 32'd1);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      pat  = tbl[i].pat;
      run_txn(tbl[i].cmd, 0, 0, lat, rd);
      chk($sformatf("tbl%0d_latency", i), lat, 521);
      chk($sformatf("tbl%0d_rd", i), {16'd0, rd}, {16'd0, tbl[i].exp_rd});
      chk($sformatf("tbl%0d_rises", i), rises, 16);
      chk($sformatf("tbl%0d_falls", i), falls, 16);
      chk($sformatf("tbl%0d_mosi", i), {16'd0, mosi_q}, {16'd0, tbl[i].cmd});
      repeat (4) @(posedge clk);
    end

    // Random transactions: MISO word is captured MSB first, MOSI carries cmd MSB first
    for (int k = 0; k < 6; k++) begin
      c = 16'($urandom);
      if (k % 2 == 0) begin
        mode = 0;
        pat  = c;
      end else begin
        mode = 4;
        pat  = 16'($urandom);
      end
      run_txn(c, 0, 0, lat, rd);
      chk($sformatf("rnd%0d_latency", k), lat, 521);
      chk($sformatf("rnd%0d_rd", k), {16'd0, rd}, {16'd0, pat});
      chk($sformatf("rnd%0d_mosi", k), {16'd0, mosi_q}, {16'd0, c});
      chk($sformatf("rnd%0d_edges", k), rises * 100 + falls, 1616);
      repeat (2) @(posedge clk);
    end

    // wrt re-pulsed mid-transaction is ignored
    mode = 0;
    run_txn(16'h0D02, 100, 0, lat, rd);
    chk("repulse_latency", lat, 521);
    chk("repulse_rd", {16'd0, rd}, 32'h0D02);

    // wrt on the completing edge is ignored
    run_txn(16'h3C5A, 521, 0, lat, rd);
    chk("done_edge_latency", lat, 521);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("done_edge_ss_n%0d", j), {31'd0, SS_n}, 32'd1);
      chk($sformatf("done_edge_hold%0d", j), {31'd0, done}, 32'd1);
    end
    chk("done_edge_rd", {16'd0, rd_data}, 32'h3C5A);

    // Back-to-back: second wrt one clk after done
    run_txn(16'hA1B2, 0, 0, lat, rd);
    chk("b2b_first_rd", {16'd0, rd}, 32'hA1B2);
    chk("b2b_ss_gap", {31'd0, SS_n}, 32'd1);
    run_txn(16'h5E3C, 0, 0, lat, rd);
    chk("b2b_second_latency", lat, 521);
    chk("b2b_second_rd", {16'd0, rd}, 32'h5E3C);
    repeat (2) @(posedge clk);

    // Reset mid-transaction aborts with no later done
    run_txn(16'h7777, 0, 200, lat, rd);
    dcount = 0;
    for (int j = 0; j < 600; j++) begin
      @(posedge clk);
      #1;
      if (done || !SS_n) dcount++;
    end
    chk("abort_quiet", dcount, 0);
    run_txn(16'h0D02, 0, 0, lat, rd);
    chk("post_reset_latency", lat, 521);
    chk("post_reset_rd", {16'd0, rd}, 32'h0D02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mstr16.md
SPI_MSTR16 -- requirements
Module: spi_mstr16

Interface
REQ-001 Parameter SCLK_DIV_W, default 5, width of the SCLK divider; SCLK period = 2^SCLK_DIV_W clk (32 by default).
REQ-002 clk  input  1  system clock; all flops use the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wrt  input  1  one-clk pulse that starts a 16-bit transaction with cmd.
REQ-005 cmd  input  16  command word. [15] = R/Wn (1 = read), [14:8] = register address, [7:0] = write data or don't-care.
REQ-006 done  output  1  high when a transaction completes; held until the next accepted wrt.
REQ-007 rd_data  output  16  the 16 bits captured from MISO, MSB first.
REQ-008 SS_n  output  1  active-low slave select, registered.
REQ-009 SCLK  output  1  serial clock, equal to the divider MSB; idles high.
REQ-010 MOSI  output  1  serial data out, equal to shift register bit 15.
REQ-011 MISO  input  1  serial data in from the inertial sensor.

Function
REQ-012 The SHALL-be-implemented state machine has three states: IDLE, PORCH, SHIFT.
REQ-013 IDLE: SS_n=1; divider held at the preload value 5'b10111 so SCLK=1.
REQ-014 IDLE with wrt=1: same edge loads the shift register with cmd, clears done, clears the bit counter, drives SS_n=0, preloads the divider, goes to PORCH.
REQ-015 In PORCH and SHIFT the divider increments every clk.
REQ-016 smpl event: divider == all-ones-except-MSB (01111). On this event MISO is registered into MISO_smpl, one clk before each SCLK rise.
REQ-017 shft event: divider == all-ones (11111). On this event the machine shifts: shift register <= {shift[14:0], MISO_smpl}; bit counter +1.
REQ-018 PORCH: its first shft event is the front-porch SCLK fall. No shift occurs on it, and the state goes to SHIFT.
REQ-019 SHIFT: on the shft event that brings the bit counter to 16, the machine completes the transaction in one edge:
- performs the final shift;
- reloads the divider preload, so SCLK stays high with no 17th fall;
- sets SS_n=1 and done=1;
- returns to IDLE.
REQ-020 Edge counts per transaction: exactly 16 SCLK rises and 16 SCLK falls while SS_n=0. The first fall precedes the first rise.
REQ-021 Latency: done rises on the 521st clk edge after the edge that sampled wrt (SCLK_DIV_W=5).
REQ-022 MOSI changes only on SCLK falls or at wrt load, so it is stable at every SCLK rise.
REQ-023 rd_data = shift register contents; they are valid whenever done=1.
REQ-024 wrt in PORCH or SHIFT is ignored: no reload and no restart.
REQ-025 wrt on the same edge that done sets is ignored. wrt one clk later starts a new transaction normally.
REQ-026 SS_n falls at least 9 clk before the first SCLK fall. SS_n rises no earlier than 16 clk after the last SCLK rise.

Reset
REQ-027 rst_n low, asynchronously:
- state=IDLE, SS_n=1, SCLK=1 (divider=preload), done=0;
- shift register=16'h0000 (MOSI=0), bit counter=0, MISO_smpl=0.
REQ-028 Reset asserted mid-transaction aborts it immediately. No done pulse follows, and a new wrt after release behaves per REQ-014.

Structure
REQ-029 Shared package spi_pkg holds:
- the state enum {IDLE, PORCH, SHIFT};
- localparam SCLK_PRELOAD (5'b10111);
- localparam SPI_LEN = 16.
REQ-030 Single module with no sub-modules. The divider, bit counter, shift register and FSM are inline.

Verification
REQ-031 Loopback (MISO tied to MOSI), wrt with cmd=16'h0D02 -> done at edge 521, rd_data=16'h0D02.
REQ-032 MISO tied 1, then tied 0, cmd=16'h8F00 -> rd_data=16'hFFFF, then 16'h0000. Counter on the bench sees 16 rises and 16 falls of SCLK per SS_n low window.
REQ-033 Against the inertial sensor model, write cmd=16'h0D02 -> rd_data[7:0]=8'hA5. After SS_n rises, the sensor's register 0x0D reads back 8'h02 via cmd=16'h8D00.
REQ-034 wrt re-pulsed at edge 100 of a transaction -> no effect; done still at edge 521 and rd_data unchanged from the single-transaction case.
REQ-035 rst_n pulsed low at edge 200 -> SS_n=1, SCLK=1, done=0 within the same cycle. The next wrt completes a correct transaction.
REQ-036 Back-to-back: wrt one clk after done -> done drops, SS_n is high for at least 1 clk between transactions, and the second rd_data is correct.
